// File: rtl/ddc_decim_ctrl.sv
// Reconfiguration controller for a cascade of decimate-by-2 stages. On a new
// stage count it drains the chain, applies the new bypass pattern, flushes it with zeros, and masks settling outputs.
//
// state | meaning
// RUN   | source and config pass through, settling outputs masked by discard count
// DRAIN | source blocked, in-flight old-config samples still reach dst
// FLUSH | zero samples injected, new bypass applied, all outputs suppressed
module ddc_decim_ctrl #(
  parameter int N_STAGES     = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int OUT_WIDTH    = 48,
  parameter int DRAIN_CYCLES = 32,
  parameter int FLUSH_LEN    = 64,
  parameter int DISCARD_LEN  = 4,
  parameter int RESET_STAGES = N_STAGES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(N_STAGES+1)-1:0]   cfg_stages,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [DATA_WIDTH-1:0]           src_data,
  input  logic                            src_valid,
  output logic                            src_ready,
  output logic [DATA_WIDTH-1:0]           chain_data,
  output logic                            chain_valid,
  output logic [N_STAGES-1:0]             stage_bypass,
  input  logic [OUT_WIDTH-1:0]            chain_out_data,
  input  logic                            chain_out_valid,
  output logic [OUT_WIDTH-1:0]            dst_data,
  output logic                            dst_valid,
  output logic [$clog2(N_STAGES+1)-1:0]   active_stages,
  output logic                            busy
);

  localparam int SW   = $clog2(N_STAGES+1);
  localparam int CMAX = (DRAIN_CYCLES > FLUSH_LEN) ? DRAIN_CYCLES : FLUSH_LEN;
  localparam int CW   = $clog2(CMAX+1);
  localparam int DW   = (DISCARD_LEN > 0) ? $clog2(DISCARD_LEN+1) : 1;

  localparam logic [SW-1:0] N_MAX        = SW'(N_STAGES);
  localparam logic [SW-1:0] RST_ACTIVE   = SW'(RESET_STAGES);
  localparam logic [CW-1:0] DRAIN_LOAD   = CW'(DRAIN_CYCLES-1);
  localparam logic [CW-1:0] FLUSH_LOAD   = CW'(FLUSH_LEN-1);
  localparam logic [DW-1:0] DISCARD_LOAD = DW'(DISCARD_LEN);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [DW-1:0]       discard, discard_nxt;
  logic [SW-1:0]       pending, pending_nxt;
  logic [SW-1:0]       active_nxt;
  logic [N_STAGES-1:0] bypass_nxt;
  logic [SW-1:0]       req;

  function automatic logic [N_STAGES-1:0] bypass_of(input logic [SW-1:0] n);
    logic [N_STAGES-1:0] b;
    for (int i = 0; i < N_STAGES; i++) b[i] = (i >= int'(n));
    return b;
  endfunction

  assign req      = (cfg_stages > N_MAX) ? N_MAX : cfg_stages;
  assign dst_data = chain_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= '0;
      discard       <= '0;
      pending       <= RST_ACTIVE;
      active_stages <= RST_ACTIVE;
      stage_bypass  <= bypass_of(RST_ACTIVE);
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      discard       <= discard_nxt;
      pending       <= pending_nxt;
      active_stages <= active_nxt;
      stage_bypass  <= bypass_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    discard_nxt = discard;
    pending_nxt = pending;
    active_nxt  = active_stages;
    bypass_nxt  = stage_bypass;
    src_ready   = 1'b0;
    cfg_ready   = 1'b0;
    chain_valid = 1'b0;
    chain_data  = '0;
    dst_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      RUN: begin
        src_ready   = 1'b1;
        cfg_ready   = 1'b1;
        chain_valid = src_valid;
        chain_data  = src_data;
        if (discard == '0) dst_valid = chain_out_valid;
        else if (chain_out_valid) discard_nxt = discard - DW'(1);
        // A request equal to the applied count is absorbed without a flush.
        if (cfg_valid && (req != active_stages)) begin
          pending_nxt = req;
          cnt_nxt     = DRAIN_LOAD;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        dst_valid = chain_out_valid;
        if (cnt == '0) begin
          state_nxt  = FLUSH;
          cnt_nxt    = FLUSH_LOAD;
          active_nxt = pending;
          bypass_nxt = bypass_of(pending);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      FLUSH: begin
        busy        = 1'b1;
        chain_valid = 1'b1;
        if (cnt == '0) begin
          state_nxt   = RUN;
          discard_nxt = DISCARD_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: doc/ddc_decim_ctrl.md
# ddc_decim_ctrl

Reconfiguration controller for the DDC decimate-by-2 cascade: N_STAGES polyphase decimate-by-2 stages, each with its own bypass input. It sits between the sample source and the first stage and owns every stage's bypass control. On a new decimation setting it drains the chain, updates the bypass pattern, flushes all filter delay lines with zero samples, and masks the first settling outputs. Downstream therefore never sees samples that mix old- and new-configuration history.

## Interface
- N_STAGES, 4, number of cascaded decimate-by-2 stages
- DATA_WIDTH, 16, source sample width
- OUT_WIDTH, 48, chain output word width
- DRAIN_CYCLES, 32, idle cycles allowed for in-flight samples to exit the chain (≥ 1)
- FLUSH_LEN, 64, zero samples injected to clear delay lines (≥ 1)
- DISCARD_LEN, 4, chain outputs suppressed after flush (≥ 0)
- RESET_STAGES, N_STAGES, active stage count after reset (0..N_STAGES)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_stages  in  $clog2(N_STAGES+1)  requested active stage count
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- src_data  in  DATA_WIDTH  source sample
- src_valid  in  1  source sample valid
- src_ready  out  1  controller accepts source sample
- chain_data  out  DATA_WIDTH  sample to stage 0
- chain_valid  out  1  sample valid to stage 0
- stage_bypass  out  N_STAGES  bypass per stage; bit i drives stage i
- chain_out_data  in  OUT_WIDTH  last-stage output
- chain_out_valid  in  1  last-stage output valid
- dst_data  out  OUT_WIDTH  gated output (= chain_out_data, combinational)
- dst_valid  out  1  gated output valid
- active_stages  out  $clog2(N_STAGES+1)  currently applied stage count
- busy  out  1  high in DRAIN or FLUSH

## Operation
- States: RUN, DRAIN, FLUSH. Reset: RUN, active_stages=RESET_STAGES, stage_bypass[i]=(i ≥ RESET_STAGES), discard count 0, internal counter 0. Outputs at reset: cfg_ready=1, src_ready=1, busy=0, dst_valid=0.
- RUN:
  - src_ready=1, cfg_ready=1.
  - chain_valid=src_valid, chain_data=src_data.
  - dst_valid=chain_out_valid when discard count is 0. Otherwise dst_valid=0 and each chain_out_valid decrements the discard count.
- Config accept (cfg_valid & cfg_ready):
  - Requested value = min(cfg_stages, N_STAGES).
  - Equal to active_stages: no-op, state stays RUN, discard count unchanged.
  - Different: latch the pending value and go to DRAIN.
- DRAIN:
  - src_ready=0, cfg_ready=0, chain_valid=0, chain_data=0.
  - dst_valid=chain_out_valid, so old-config outputs still pass through.
  - Lasts exactly DRAIN_CYCLES cycles, then FLUSH.
  - On entering FLUSH, active_stages and stage_bypass take the pending value.
- FLUSH:
  - chain_valid=1, chain_data=0 for exactly FLUSH_LEN cycles.
  - src_ready=0, cfg_ready=0, dst_valid=0.
  - Then RUN with discard count=DISCARD_LEN.
  - Outputs arriving during FLUSH do not decrement the discard count.
- cfg_valid held during DRAIN/FLUSH waits; it is accepted in the first RUN cycle.
- rst mid-sequence aborts it; the pending value is lost and the controller returns to reset values.
- src_valid while src_ready=0 is ignored. The source must hold the sample (valid/ready semantics).

## Timing
- Config handshake in cycle t (value different from active_stages):
  - DRAIN occupies cycles t+1..t+DRAIN_CYCLES.
  - FLUSH occupies cycles t+DRAIN_CYCLES+1..t+DRAIN_CYCLES+FLUSH_LEN.
  - stage_bypass and active_stages change at the start of cycle t+DRAIN_CYCLES+1.
  - src_ready and cfg_ready return high in cycle t+DRAIN_CYCLES+FLUSH_LEN+1.
- busy=1 exactly in DRAIN and FLUSH cycles.
- Data path latency:
  - src to chain: 0 cycles (combinational mux).
  - chain_out to dst: 0 cycles.
- stage_bypass, active_stages and state are registered.
- Counter width: $clog2(max(DRAIN_CYCLES, FLUSH_LEN)+1). Discard count width: $clog2(DISCARD_LEN+1).

## Test plan
- Reset:
  - rst high 3 cycles with RESET_STAGES=4 → stage_bypass=4'b0000, active_stages=4, src_ready=1, cfg_ready=1, busy=0, dst_valid=0.
  - Feed 8 samples → chain_valid/chain_data mirror src 1:1, and dst mirrors chain_out.
- Reconfig 4→2 accepted at cycle 10, defaults:
  - busy high cycles 11..106.
  - chain_valid=0 in cycles 11..42; chain_valid=1 with data 0 in cycles 43..106.
  - stage_bypass=4'b1100 from cycle 43.
  - src_ready high at cycle 107.
  - First 4 chain_out_valid pulses after cycle 106 are masked; the 5th appears on dst_valid.
- No-op request: cfg_stages=2 while active_stages=2 → busy stays 0, no flush, no chain_valid gap.
- Clamp:
  - cfg_stages=7, N_STAGES=4, active_stages=1 → active_stages=4 and stage_bypass=0 after drain.
  - cfg_stages=0 → stage_bypass=4'b1111.
- cfg_valid held high through a reconfig, with the new value ≠ active → second request accepted exactly in the first RUN cycle, and a second DRAIN starts the next cycle.
- rst asserted mid-FLUSH → next cycle state RUN, stage_bypass reflects RESET_STAGES, chain_valid follows src_valid, no residual zero injection.
